// File: rtl/mux_n_pipe_if.sv
// Handshake/bus bundle between operand fetch and the registered operand mux.
// The master modport is the side that drives the input (upstream) and consumes the output.
interface mux_n_pipe_if #(
    parameter int BITWIDTH = 32,
    parameter int NUM_IN   = 4,
    parameter int SEL_W    = 2
);
    logic [SEL_W-1:0]           sel;
    logic [NUM_IN*BITWIDTH-1:0] in_bus;
    logic                       in_valid;
    logic                       in_ready;
    logic [BITWIDTH-1:0]        out_data;
    logic                       out_sel_err;
    logic                       out_valid;
    logic                       out_ready;
    logic [1:0]                 count;

    modport master (
        output sel, in_bus, in_valid, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid, count
    );

    modport slave (
        input  sel, in_bus, in_valid, out_ready,
        output in_ready, out_data, out_sel_err, out_valid, count
    );
endinterface

// File: rtl/mux_n_pipe.sv
// Registered N-input operand select feeding a 2-entry skid buffer.
// in_ready depends only on registered state (and reset), so the ALU can stall
// without a combinational path from out_ready back into decode.
module mux_n_pipe #(
    parameter int BITWIDTH = 32,
    parameter int NUM_IN   = 4,
    parameter int SEL_W    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_n_pipe_if.slave bus
);
    // Elaboration-time parameter sanity.
    if ((1 << SEL_W) < NUM_IN) begin : g_bad_sel_w
        $error("mux_n_pipe: 2**SEL_W must be >= NUM_IN");
    end
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("mux_n_pipe: NUM_IN must be in 2..16");
    end

    // Widened so NUM_IN == 2**SEL_W is representable; err is then constant 0.
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    typedef struct packed {
        logic                err;
        logic [BITWIDTH-1:0] data;
    } ent_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    ent_t   r_head;
    ent_t   r_skid;
    ent_t   w_word;
    logic   w_accept;
    logic   w_pop;
    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_load_head_in;
    logic   w_load_head_skid;
    logic   w_load_skid;

    // Ready is held low during reset and otherwise only reflects the registered fill level.
    assign w_in_ready  = rst_n & (r_state != ST_TWO);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    // Select the addressed word; out-of-range selects yield zero with the error flag set.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) w_word.data = bus.in_bus[k*BITWIDTH +: BITWIDTH];
        end
        w_word.err = ({1'b0, bus.sel} >= NUM_IN_W);
    end

    // Next fill state and which storage register loads on this edge.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_head_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Skid always drains into head, so ordering stays FIFO.
                if (w_pop) begin
                    w_state_nxt      = ST_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Fill-state register; reset drops both entries without an output pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Head register only changes on a load, so the presented word is stable until popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_head <= '0;
        else if (w_load_head_in)   r_head <= w_word;
        else if (w_load_head_skid) r_head <= r_skid;
    end

    // Skid register captures the word accepted while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_skid <= '0;
        else if (w_load_skid) r_skid <= w_word;
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = r_head.data;
    assign bus.out_sel_err = r_head.err;
    assign bus.count       = r_state;
endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench: a 4-input and a 3-input instance, checked against a
// queue model of a 2-deep FIFO fed by an idealised select function.
module tb_mux_n_pipe;
    localparam int BW = 32;
    localparam logic [4*BW-1:0] BUS_ABCD = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

    typedef struct packed {
        logic          err;
        logic [BW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    ent_t q4[$];
    ent_t q3[$];

    mux_n_pipe_if #(.BITWIDTH(BW), .NUM_IN(4), .SEL_W(2)) if4 ();
    mux_n_pipe_if #(.BITWIDTH(BW), .NUM_IN(3), .SEL_W(2)) if3 ();

    mux_n_pipe #(.BITWIDTH(BW), .NUM_IN(4), .SEL_W(2)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    mux_n_pipe #(.BITWIDTH(BW), .NUM_IN(3), .SEL_W(2)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    always #5 clk = ~clk;

    // Ideal select: word k of the bus, or zero with error when k is not a real input.
    function automatic ent_t ref_word(input logic [1:0] s, input logic [4*BW-1:0] b, input int nin);
        ent_t e;
        if (int'(s) >= nin) begin
            e.err  = 1'b1;
            e.data = '0;
        end else begin
            e.err  = 1'b0;
            e.data = b[int'(s)*BW +: BW];
        end
        return e;
    endfunction

    // Advance one clock: decide transfers from the model's fill level, then update queues.
    task automatic step();
        bit   a4, p4, a3, p3;
        ent_t e4, e3;
        a4 = (if4.in_valid === 1'b1) && (q4.size() < 2);
        p4 = (if4.out_ready === 1'b1) && (q4.size() > 0);
        a3 = (if3.in_valid === 1'b1) && (q3.size() < 2);
        p3 = (if3.out_ready === 1'b1) && (q3.size() > 0);
        e4 = ref_word(if4.sel, if4.in_bus, 4);
        e3 = ref_word(if3.sel, {32'h0, if3.in_bus}, 3);
        @(posedge clk);
        #1;
        if (p4) void'(q4.pop_front());
        if (a4) q4.push_back(e4);
        if (p3) void'(q3.pop_front());
        if (a3) q3.push_back(e3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if4.sel = '0; if4.in_bus = '0; if4.in_valid = 1'b0; if4.out_ready = 1'b0;
        if3.sel = '0; if3.in_bus = '0; if3.in_valid = 1'b0; if3.out_ready = 1'b0;
        #3;
        n_cmp++; if (if4.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", if4.in_ready); end
        n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", if4.out_valid); end
        n_cmp++; if (if4.count !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", if4.count); end
        n_cmp++; if (if4.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", if4.out_data); end
        n_cmp++; if (if4.out_sel_err !== 1'b0) begin n_err++; $display("FAIL reset_sel_err: got %b want 0", if4.out_sel_err); end
        n_cmp++; if (if3.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready3: got %b want 0", if3.in_ready); end
        #9;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (if4.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", if4.in_ready); end
        n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL release_out_valid: got %b want 0", if4.out_valid); end
    endtask

    task automatic test_single();
        if4.in_bus = BUS_ABCD; if4.sel = 2'd2; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
        step();
        if4.in_valid = 1'b0;
        n_cmp++; if (if4.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", if4.out_valid); end
        n_cmp++; if (if4.out_data !== 32'hCCCC0002) begin n_err++; $display("FAIL single_data: got %h want cccc0002", if4.out_data); end
        n_cmp++; if (if4.out_sel_err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", if4.out_sel_err); end
        n_cmp++; if (if4.count !== 2'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", if4.count); end
        step();
        n_cmp++; if (if4.count !== 2'd0) begin n_err++; $display("FAIL single_drain: got %0d want 0", if4.count); end
    endtask

    task automatic test_stream();
        logic [BW-1:0] exp;
        if4.in_bus = BUS_ABCD; if4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if4.sel = 2'(i); if4.in_valid = 1'b1;
            n_cmp++; if (if4.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 1", i, if4.in_ready); end
            step();
            exp = BUS_ABCD[i*BW +: BW];
            n_cmp++; if (if4.out_valid !== 1'b1 || if4.out_data !== exp) begin
                n_err++; $display("FAIL stream_data[%0d]: got v=%b %h want v=1 %h", i, if4.out_valid, if4.out_data, exp);
            end
        end
        if4.in_valid = 1'b0;
        step();
        n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_end: got %b want 0", if4.out_valid); end
    endtask

    task automatic test_backpressure();
        if4.in_bus = BUS_ABCD; if4.out_ready = 1'b0;
        if4.sel = 2'd1; if4.in_valid = 1'b1; step();
        if4.sel = 2'd3; step();
        n_cmp++; if (if4.count !== 2'd2) begin n_err++; $display("FAIL bp_count: got %0d want 2", if4.count); end
        n_cmp++; if (if4.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", if4.in_ready); end
        if4.sel = 2'd0; step();
        n_cmp++; if (if4.count !== 2'd2 || if4.out_data !== 32'hBBBB0001) begin
            n_err++; $display("FAIL bp_ignore: got cnt=%0d %h want cnt=2 bbbb0001", if4.count, if4.out_data);
        end
        if4.in_valid = 1'b0; if4.out_ready = 1'b1;
        step();
        n_cmp++; if (if4.out_valid !== 1'b1 || if4.out_data !== 32'hDDDD0003) begin
            n_err++; $display("FAIL bp_second: got v=%b %h want v=1 dddd0003", if4.out_valid, if4.out_data);
        end
        step();
        n_cmp++; if (if4.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0 (data %h)", if4.out_valid, if4.out_data); end
    endtask

    task automatic test_out_of_range();
        if3.in_bus = BUS_ABCD[3*BW-1:0]; if3.out_ready = 1'b1;
        if3.sel = 2'd3; if3.in_valid = 1'b1;
        step();
        n_cmp++; if (if3.out_data !== 32'h0 || if3.out_sel_err !== 1'b1) begin
            n_err++; $display("FAIL oor_err: got %h err=%b want 0 err=1", if3.out_data, if3.out_sel_err);
        end
        if3.sel = 2'd1;
        step();
        n_cmp++; if (if3.out_data !== 32'hBBBB0001 || if3.out_sel_err !== 1'b0) begin
            n_err++; $display("FAIL oor_clear: got %h err=%b want bbbb0001 err=0", if3.out_data, if3.out_sel_err);
        end
        if3.in_valid = 1'b0;
        step();
        n_cmp++; if (if3.count !== 2'd0) begin n_err++; $display("FAIL oor_drain: got %0d want 0", if3.count); end
    endtask

    task automatic test_accept_pop();
        ent_t prev;
        if4.out_ready = 1'b1; if4.in_valid = 1'b1;
        if4.sel = 2'($urandom_range(3)); if4.in_bus = {$urandom, $urandom, $urandom, $urandom};
        prev = ref_word(if4.sel, if4.in_bus, 4);
        step();
        for (int i = 0; i < 10; i++) begin
            if4.sel = 2'($urandom_range(3)); if4.in_bus = {$urandom, $urandom, $urandom, $urandom};
            n_cmp++; if (if4.count !== 2'd1 || {if4.out_sel_err, if4.out_data} !== prev) begin
                n_err++; $display("FAIL accpop[%0d]: got cnt=%0d %h want cnt=1 %h", i, if4.count, if4.out_data, prev.data);
            end
            prev = ref_word(if4.sel, if4.in_bus, 4);
            step();
        end
        if4.in_valid = 1'b0;
        step();
        n_cmp++; if (if4.count !== 2'd0) begin n_err++; $display("FAIL accpop_drain: got %0d want 0", if4.count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if4.in_valid = 1'($urandom_range(1)); if4.out_ready = ($urandom_range(3) != 0);
            if4.sel = 2'($urandom_range(3)); if4.in_bus = {$urandom, $urandom, $urandom, $urandom};
            if3.in_valid = 1'($urandom_range(1)); if3.out_ready = 1'($urandom_range(1));
            if3.sel = 2'($urandom_range(3)); if3.in_bus = {$urandom, $urandom, $urandom};
            step();
            n_cmp++; if (if4.count !== 2'(q4.size()) || if4.out_valid !== (q4.size() != 0) || if4.in_ready !== (q4.size() < 2)) begin
                n_err++; $display("FAIL rnd4_ctl[%0d]: got cnt=%0d v=%b rdy=%b want cnt=%0d", i, if4.count, if4.out_valid, if4.in_ready, q4.size());
            end
            if (q4.size() != 0) begin
                n_cmp++; if ({if4.out_sel_err, if4.out_data} !== q4[0]) begin
                    n_err++; $display("FAIL rnd4_data[%0d]: got %b/%h want %b/%h", i, if4.out_sel_err, if4.out_data, q4[0].err, q4[0].data);
                end
            end
            n_cmp++; if (if3.count !== 2'(q3.size()) || if3.out_valid !== (q3.size() != 0) || if3.in_ready !== (q3.size() < 2)) begin
                n_err++; $display("FAIL rnd3_ctl[%0d]: got cnt=%0d v=%b rdy=%b want cnt=%0d", i, if3.count, if3.out_valid, if3.in_ready, q3.size());
            end
            if (q3.size() != 0) begin
                n_cmp++; if ({if3.out_sel_err, if3.out_data} !== q3[0]) begin
                    n_err++; $display("FAIL rnd3_data[%0d]: got %b/%h want %b/%h", i, if3.out_sel_err, if3.out_data, q3[0].err, q3[0].data);
                end
            end
        end
        if4.in_valid = 1'b0; if4.out_ready = 1'b1;
        if3.in_valid = 1'b0; if3.out_ready = 1'b1;
        step(); step();
        n_cmp++; if (if4.count !== 2'd0 || if3.count !== 2'd0) begin
            n_err++; $display("FAIL rnd_drain: got %0d/%0d want 0/0", if4.count, if3.count);
        end
    endtask

    task automatic test_async_reset();
        if4.in_bus = BUS_ABCD; if4.out_ready = 1'b0; if4.in_valid = 1'b1;
        if4.sel = 2'd2; step();
        if4.sel = 2'd3; step();
        if4.in_valid = 1'b0;
        n_cmp++; if (if4.count !== 2'd2) begin n_err++; $display("FAIL arst_fill: got %0d want 2", if4.count); end
        #2;
        rst_n = 1'b0;
        #1;
        q4.delete(); q3.delete();
        n_cmp++; if (if4.out_valid !== 1'b0 || if4.count !== 2'd0 || if4.out_data !== 32'h0 || if4.out_sel_err !== 1'b0) begin
            n_err++; $display("FAIL arst_clear: got v=%b cnt=%0d %h err=%b want 0/0/0/0", if4.out_valid, if4.count, if4.out_data, if4.out_sel_err);
        end
        n_cmp++; if (if4.in_ready !== 1'b0) begin n_err++; $display("FAIL arst_in_ready: got %b want 0", if4.in_ready); end
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (if4.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_release: got %b want 1", if4.in_ready); end
        if4.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (if4.out_valid !== 1'b0 || if4.count !== 2'd0) begin
                n_err++; $display("FAIL arst_idle[%0d]: got v=%b cnt=%0d want 0/0", i, if4.out_valid, if4.count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_out_of_range();
        test_accept_pop();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-input, registered successor to the combinational operand-select muxes in the CPU datapath.
- Selects one of NUM_IN words per transfer and registers the result into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between the operand-fetch stage and the ALU. It lets the ALU stall without a combinational ready path back into decode.
- Out-of-range selects are flagged rather than silently zeroed.

Parameters:
- BITWIDTH, 32, width of each data input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  SEL_W  input index, sampled with in_valid.
- in_bus  input  NUM_IN*BITWIDTH  flattened inputs; input k occupies bits [k*BITWIDTH +: BITWIDTH].
- in_valid  input  1  upstream holds sel/in_bus valid.
- in_ready  output  1  block can accept this cycle.
- out_data  output  BITWIDTH  selected word, head of buffer.
- out_sel_err  output  1  head entry had sel >= NUM_IN.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head this cycle.
- count  output  2  occupancy: 0, 1 or 2.

Behaviour:
- Handshakes:
  - accept = in_valid & in_ready; pop = out_valid & out_ready, both evaluated at the rising edge.
  - Once out_valid rises, out_data and out_sel_err stay stable until pop; there is no retraction.
- Mux function, evaluated on accept:
  - word = in_bus slice [sel].
  - If sel >= NUM_IN: word = 0 and err = 1; otherwise err = 0.
- Storage:
  - Head register (data+err) drives out_data and out_sel_err.
  - Skid register (data+err) is internal.
- State machine, held in count:
  - EMPTY (0): out_valid=0, in_ready=1.
    - accept -> ONE, head <= word.
  - ONE (1): out_valid=1, in_ready=1.
    - accept & pop -> ONE, head <= new word.
    - accept & !pop -> TWO, skid <= word, head held.
    - pop & !accept -> EMPTY.
    - neither -> ONE, hold.
  - TWO (2): out_valid=1, in_ready=0; in_valid is ignored.
    - pop -> ONE, head <= skid.
    - !pop -> hold.
- Timing:
  - Latency: 1 cycle from accept to out_valid when buffer empty or head popped the same edge.
  - Throughput: 1 word/cycle sustained when out_ready stays high.
  - in_ready is a function of registered state only. No combinational path from out_ready to in_ready, and none from inputs to outputs.
- Ordering: strict FIFO; a skid word never overtakes the head.
- Reset (asynchronous, rst_n low):
  - count=0, out_valid=0, out_data=0, out_sel_err=0, skid=0.
  - in_ready is forced 0 while rst_n is low and returns to 1 on the first clock-independent deassertion.
  - Reset mid-transfer discards both entries with no output pulse.
- Out-of-range selects are unreachable when NUM_IN = 2**SEL_W; err then stays 0.
- Hold behaviour: head and skid registers update only on the transitions listed; no toggling of idle registers.

Test Plan:
- Reset, then NUM_IN=4, BITWIDTH=32, in_bus = {D,C,B,A} = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, sel=2, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0xCCCC0002, out_sel_err=0, count=1; following cycle count=0.
- Streaming: sel=0,1,2,3 on consecutive cycles, out_ready=1 -> outputs 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 on 4 consecutive cycles; in_ready constantly 1.
- Backpressure: out_ready=0, push sel=1 then sel=3 -> count=2, in_ready=0, third push with sel=0 ignored; raise out_ready -> 0xBBBB0001 then 0xDDDD0003, then out_valid=0; the sel=0 word never appears.
- NUM_IN=3, SEL_W=2, sel=3 -> out_data=0, out_sel_err=1; next transfer with sel=1 -> out_sel_err=0.
- Simultaneous accept+pop in ONE state for 10 cycles -> count stays 1 and data order is preserved.
- Assert rst_n low asynchronously (mid-cycle) with count=2 -> out_valid, count, out_data drop to 0 immediately, in_ready=0; after release with no input, out_valid stays 0.
